noc_port_arbiter: RTL and testbench

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

---
 rtl/noc_arb_pkg.sv | 12 +
 rtl/rr_pick_0001.sv | 14 +
 rtl/noc_port_arbiter.sv | 70 +++++++
 tb/tb_noc_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared port width, types and one-hot helpers for the NoC port arbiter
package noc_arb_pkg;
  localparam int NUM_PORTS = 4;
  typedef logic [NUM_PORTS-1:0] port_vec_t;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic port_vec_t lowest(port_vec_t v);
    return v & (~v + port_vec_t'(1));
  endfunction
  function automatic port_vec_t start_onehot(port_vec_t p);
    return (p == '0) ? port_vec_t'(1) : lowest(p);
  endfunction
endpackage

// File: rtl/rr_pick_0001.sv
// rr_pick_0001: combinational rotating-priority pick, first requester at or above the priority index, wrapping
module rr_pick_0001
  import noc_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] pri,
  output logic [3:0] pick
);
  port_vec_t start;
  port_vec_t hi;
  assign start = start_onehot(pri);
  assign hi    = req & ~(start - port_vec_t'(1));
  assign pick  = (hi != '0) ? lowest(hi) : lowest(req);
endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: 4-port wormhole output arbiter; optional no-progress timeout under NOC_ARB_TIMEOUT_EN
module noc_port_arbiter
  import noc_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_i,
  input  logic [3:0] tail_i,
  input  logic       ready_i,
  input  logic [3:0] priority_order_i,
  output logic [3:0] grant_o,
  output logic       fire_o,
  output logic       change_order_o,
  output logic       busy_o,
  output logic       timeout_o
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  arb_state_e state;
  logic [3:0] pick;
  logic       tail_fire;
  logic       expire;
  rr_pick_0001 u_pick (
    .req  (req_i),
    .pri  (priority_order_i),
    .pick (pick)
  );
  assign fire_o    = |(grant_o & req_i) & ready_i;
  assign tail_fire = fire_o & |(grant_o & tail_i);
`ifdef NOC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  assign expire = !fire_o && cnt == CW'(TIMEOUT_CYCLES - 1);
  // count locked cycles without progress; any transfer or leaving LOCKED clears it
  always_ff @(posedge clk)
    cnt <= (reset || state != LOCKED || fire_o || expire) ? '0 : cnt + CW'(1);
  // forced-release pulse, coincident with the rotation request
  always_ff @(posedge clk)
    timeout_o <= !reset && state == LOCKED && expire;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif
  // arbitrate in IDLE (skipping the post-release bubble so the rotated priority is used), hold the lock until tail or timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      grant_o        <= '0;
      busy_o         <= 1'b0;
      change_order_o <= 1'b0;
    end else if (state == IDLE) begin
      change_order_o <= 1'b0;
      if (!change_order_o && req_i != '0) begin
        state   <= LOCKED;
        grant_o <= pick;
        busy_o  <= 1'b1;
      end
    end else if (tail_fire || expire) begin
      state          <= IDLE;
      grant_o        <= '0;
      busy_o         <= 1'b0;
      change_order_o <= 1'b1;
    end else begin
      change_order_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: directed and randomized checks of noc_port_arbiter against a behavioural model
module tb_noc_port_arbiter;
`ifdef NOC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int TO    = 4;
`else
  localparam bit TO_EN = 1'b0;
  localparam int TO    = 16;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] tail = '0;
  logic       ready = 1'b0;
  logic [3:0] pri = '0;
  logic [3:0] grant;
  logic       fire;
  logic       chg;
  logic       busy;
  logic       to;
  int total = 0;
  int bad = 0;
  int m_port = -1;
  bit m_chg = 1'b0;
  bit m_to = 1'b0;
  int m_cnt = 0;

  noc_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_i            (req),
    .tail_i           (tail),
    .ready_i          (ready),
    .priority_order_i (pri),
    .grant_o          (grant),
    .fire_o           (fire),
    .change_order_o   (chg),
    .busy_o           (busy),
    .timeout_o        (to)
  );

  always #5 clk = ~clk;

  function automatic int pick_m(logic [3:0] r, logic [3:0] p);
    int s = 0;
    for (int i = 3; i >= 0; i--) if (p[i]) s = i;
    for (int k = 0; k < 4; k++) if (r[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] eg();
    logic [3:0] v = '0;
    if (m_port >= 0) v[m_port] = 1'b1;
    return v;
  endfunction

  function automatic bit ef();
    return m_port >= 0 && req[m_port] && ready;
  endfunction

  task automatic model_step();
    bit f;
    if (reset) begin
      m_port = -1; m_chg = 0; m_to = 0; m_cnt = 0;
    end else if (m_port < 0) begin
      m_port = (!m_chg && req != 0) ? pick_m(req, pri) : -1;
      m_chg = 0; m_to = 0; m_cnt = 0;
    end else begin
      f = ef();
      if (f && tail[m_port]) begin
        m_port = -1; m_chg = 1; m_to = 0; m_cnt = 0;
      end else if (TO_EN && !f && m_cnt == TO - 1) begin
        m_port = -1; m_chg = 1; m_to = 1; m_cnt = 0;
      end else begin
        m_cnt = f ? 0 : m_cnt + 1; m_chg = 0; m_to = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_port(int p);
    req = 4'b0001 << p; tail = req; ready = 1'b1;
    tick();
    req = '0; tail = '0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req = 4'($urandom); tail = 4'($urandom); ready = 1'($urandom); pri = 4'($urandom);
      tick();
      total += 5;
      if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
      if (chg !== 1'b0) begin bad++; $display("FAIL reset_chg got=%b want=0", chg); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (to !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", to); end
      if (fire !== 1'b0) begin bad++; $display("FAIL reset_fire got=%b want=0", fire); end
    end
    reset = 1'b0; req = '0; tail = '0; ready = 1'b1;
    tick();
    total += 2;
    if (grant !== 4'b0) begin bad++; $display("FAIL post_reset_grant got=%b want=0000", grant); end
    if (fire !== 1'b0) begin bad++; $display("FAIL post_reset_fire got=%b want=0", fire); end
  endtask

  task automatic test_pick();
    pri = 4'b0100; req = 4'b1011; tail = '0; ready = 1'b0;
    tick();
    total += 3;
    if (grant !== 4'b1000) begin bad++; $display("FAIL pick_wrap grant got=%b want=1000", grant); end
    if (busy !== 1'b1) begin bad++; $display("FAIL pick_wrap busy got=%b want=1", busy); end
    if (grant !== eg()) begin bad++; $display("FAIL pick_wrap model got=%b want=%b", grant, eg()); end
    release_port(3);
    pri = 4'b0000; req = 4'b0110;
    tick();
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL pick_zero_pri grant got=%b want=0010", grant); end
    release_port(1);
    pri = 4'b1010; req = 4'b0101;
    tick();
    total++;
    if (grant !== 4'b0100) begin bad++; $display("FAIL pick_multi_pri grant got=%b want=0100", grant); end
    release_port(2);
  endtask

  task automatic test_packet();
    pri = 4'b0010; req = 4'b0010; tail = '0; ready = 1'b1;
    tick();
    total++;
    if (grant !== 4'b0010) begin bad++; $display("FAIL packet_grant got=%b want=0010", grant); end
    for (int i = 0; i < 3; i++) begin
      tail = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      total++;
      if (fire !== 1'b1) begin bad++; $display("FAIL packet_fire flit=%0d got=%b want=1", i, fire); end
      tick();
    end
    total += 2;
    if (grant !== 4'b0) begin bad++; $display("FAIL packet_release grant got=%b want=0000", grant); end
    if (chg !== 1'b1) begin bad++; $display("FAIL packet_change got=%b want=1", chg); end
    req = '0; tail = '0;
    tick();
    total += 2;
    if (chg !== 1'b0) begin bad++; $display("FAIL packet_change_pulse got=%b want=0", chg); end
    if (fire !== 1'b0) begin bad++; $display("FAIL packet_idle_fire got=%b want=0", fire); end
    pri = 4'b1000; req = 4'b1000; tail = 4'b1000;
    tick();
    #1;
    total += 2;
    if (grant !== 4'b1000) begin bad++; $display("FAIL single_flit grant got=%b want=1000", grant); end
    if (fire !== 1'b1) begin bad++; $display("FAIL single_flit fire got=%b want=1", fire); end
    tick();
    total += 2;
    if (grant !== 4'b0) begin bad++; $display("FAIL single_flit_release got=%b want=0000", grant); end
    if (chg !== 1'b1) begin bad++; $display("FAIL single_flit_change got=%b want=1", chg); end
    req = '0; tail = '0;
    tick();
  endtask

  task automatic test_stall();
    pri = 4'b0100; req = 4'b0100; tail = '0; ready = 1'b1;
    tick();
    req = 4'b1111; tail = 4'b1111; ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (fire !== 1'b0) begin bad++; $display("FAIL stall_fire cyc=%0d got=%b want=0", i, fire); end
      tick();
      total += 2;
      if (grant !== 4'b0100) begin bad++; $display("FAIL stall_grant cyc=%0d got=%b want=0100", i, grant); end
      if (chg !== 1'b0) begin bad++; $display("FAIL stall_change cyc=%0d got=%b want=0", i, chg); end
    end
    req = '0; tail = '0; ready = 1'b1;
    tick();
    total += 2;
    if (grant !== 4'b0100) begin bad++; $display("FAIL drop_grant got=%b want=0100", grant); end
    if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b want=1", busy); end
    release_port(2);
  endtask

  task automatic test_reset_tail();
    pri = 4'b1000; req = 4'b1000; tail = '0; ready = 1'b1;
    tick();
    tail = 4'b1000; reset = 1'b1;
    #1;
    total++;
    if (fire !== 1'b1) begin bad++; $display("FAIL rst_tail_fire got=%b want=1", fire); end
    tick();
    total += 2;
    if (grant !== 4'b0) begin bad++; $display("FAIL rst_tail_grant got=%b want=0000", grant); end
    if (chg !== 1'b0) begin bad++; $display("FAIL rst_tail_change got=%b want=0", chg); end
    reset = 1'b0; req = '0; tail = '0;
    tick();
    total += 2;
    if (chg !== 1'b0) begin bad++; $display("FAIL rst_after_change got=%b want=0", chg); end
    if (fire !== 1'b0) begin bad++; $display("FAIL rst_after_fire got=%b want=0", fire); end
  endtask

  task automatic test_timeout();
    int seen = -1;
    pri = 4'b0001; req = 4'b0001; tail = '0; ready = 1'b1;
    tick();
    ready = 1'b0;
    if (TO_EN) begin
      for (int c = 1; c <= 3 * TO && seen < 0; c++) begin
        if (to === 1'b1) begin
          seen = c;
          total += 2;
          if (chg !== 1'b1) begin bad++; $display("FAIL timeout_change got=%b want=1", chg); end
          if (grant !== 4'b0) begin bad++; $display("FAIL timeout_grant got=%b want=0000", grant); end
        end else tick();
      end
      total++;
      if (seen != TO + 1) begin bad++; $display("FAIL timeout_cycle got=%0d want=%0d", seen, TO + 1); end
      req = '0;
      tick();
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL timeout_pulse got=%b want=0", to); end
    end else begin
      for (int c = 0; c < 40; c++) begin
        tick();
        total += 3;
        if (to !== 1'b0) begin bad++; $display("FAIL notimeout_to cyc=%0d got=%b want=0", c, to); end
        if (chg !== 1'b0) begin bad++; $display("FAIL notimeout_chg cyc=%0d got=%b want=0", c, chg); end
        if (grant !== 4'b0001) begin bad++; $display("FAIL notimeout_grant cyc=%0d got=%b want=0001", c, grant); end
      end
      release_port(0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom % 50) == 0;
      req   = 4'($urandom);
      tail  = ($urandom % 3 == 0) ? 4'($urandom) : 4'b0;
      ready = ($urandom % 4) != 0;
      if (chg === 1'b1) pri = {pri[2:0], pri[3]};
      else if ($urandom % 8 == 0) pri = 4'($urandom);
      #1;
      total++;
      if (fire !== ef()) begin bad++; $display("FAIL rand_fire i=%0d got=%b want=%b", i, fire, ef()); end
      tick();
      total += 4;
      if (grant !== eg()) begin bad++; $display("FAIL rand_grant i=%0d got=%b want=%b", i, grant, eg()); end
      if (chg !== m_chg) begin bad++; $display("FAIL rand_change i=%0d got=%b want=%b", i, chg, m_chg); end
      if (busy !== (m_port >= 0)) begin bad++; $display("FAIL rand_busy i=%0d got=%b want=%b", i, busy, m_port >= 0); end
      if (to !== m_to) begin bad++; $display("FAIL rand_timeout i=%0d got=%b want=%b", i, to, m_to); end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_pick();
    test_packet();
    test_stall();
    test_reset_tail();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
